// File: rtl/lpc_decoder.sv
// lpc_decoder: LPC frame to PCM synthesiser (impulse/noise excitation, 8th-order all-pole filter, one MAC per cycle)
module lpc_decoder #(
    parameter int          FRAME_LEN = 160,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          QSHIFT    = 6
) (
    input  logic        ACLK,
    input  logic        ARESET_N,
    input  logic [79:0] IN_DATA,
    input  logic        IN_VALID,
    input  logic        IN_LAST,
    output logic        IN_READY,
    output logic [15:0] TDATA,
    output logic        TVALID,
    input  logic        TREADY,
    output logic        TLAST,
    output logic        TUSER
);
    typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_t;
    state_t state, state_nx;
    logic [3:0] step;
    logic [7:0] gain, pitch, phase, phase_nx, sample_cnt;
    logic signed [7:0] coef [8];
    logic signed [15:0] hist [8];
    logic signed [31:0] acc, term, sum, scaled;
    logic signed [15:0] sat, excite, g64, g4;
    logic [15:0] lfsr, lfsr_nx;
    logic [2:0] idx;
    logic last_q, first_flag, in_xfer, out_xfer, frame_end;
    assign IN_READY  = ARESET_N && state == IDLE;
    assign in_xfer   = IN_VALID && IN_READY;
    assign TVALID    = state == OUTPUT;
    assign out_xfer  = TVALID && TREADY;
    assign frame_end = sample_cnt == 8'(FRAME_LEN - 1);
    assign TLAST     = TVALID && last_q && frame_end;
    assign TUSER     = TVALID && first_flag;
    assign g64       = {2'b00, gain, 6'b0};
    assign g4        = {6'b0, gain, 2'b00};
    assign excite    = (pitch != 8'd0) ? ((phase == 8'd0) ? g64 : 16'sd0) : (lfsr[0] ? g4 : -g4);
    assign lfsr_nx   = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    assign phase_nx  = ({1'b0, phase} + 9'd1 >= {1'b0, pitch}) ? 8'd0 : phase + 8'd1;
    // Steps 2..9 walk taps a1*y1 .. a8*y8; step 9 also produces the output sample
    assign idx       = 3'(step - 4'd2);
    assign term      = 32'(coef[idx]) * 32'(hist[idx]);
    assign sum       = acc + term;
    assign scaled    = sum >>> QSHIFT;
    assign sat       = (scaled > 32'sd32767) ? 16'sh7FFF : (scaled < -32'sd32768) ? 16'sh8000 : scaled[15:0];

    // State register
    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) state <= IDLE;
        else           state <= state_nx;
    end

    // Next-state: load frame, run the MAC sequence, hold the sample until accepted
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_xfer ? COMPUTE : IDLE;
            COMPUTE: state_nx = (step == 4'd9) ? OUTPUT : COMPUTE;
            OUTPUT:  state_nx = out_xfer ? (frame_end ? IDLE : COMPUTE) : OUTPUT;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: frame latch, accumulator, history, phase, noise source and packet flags
    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            step       <= '0;
            gain       <= '0;
            pitch      <= '0;
            phase      <= '0;
            sample_cnt <= '0;
            acc        <= '0;
            TDATA      <= '0;
            lfsr       <= LFSR_SEED;
            last_q     <= 1'b0;
            first_flag <= 1'b1;
            for (int k = 0; k < 8; k++) begin
                coef[k] <= '0;
                hist[k] <= '0;
            end
        end else begin
            if (in_xfer) begin
                gain       <= IN_DATA[79:72];
                pitch      <= IN_DATA[71:64];
                last_q     <= IN_LAST;
                sample_cnt <= '0;
                step       <= '0;
                for (int k = 0; k < 8; k++) coef[k] <= IN_DATA[63-8*k -: 8];
                if (IN_DATA[71:64] != 8'd0 && phase >= IN_DATA[71:64]) phase <= '0;
            end
            if (state == COMPUTE) begin
                step <= step + 4'd1;
                acc  <= (step == 4'd1) ? 32'(excite) * 32'sd64 : sum;
                if (step == 4'd9) TDATA <= sat;
            end
            if (out_xfer) begin
                step       <= 4'd1;
                sample_cnt <= sample_cnt + 8'd1;
                phase      <= phase_nx;
                first_flag <= 1'b0;
                lfsr       <= lfsr_nx;
                hist[0]    <= TDATA;
                for (int k = 1; k < 8; k++) hist[k] <= hist[k-1];
                if (TLAST) begin
                    phase      <= '0;
                    first_flag <= 1'b1;
                    for (int k = 0; k < 8; k++) hist[k] <= '0;
                end
            end
        end
    end
endmodule
